// File: rtl/detector_window_averager.sv
// Averages detector samples over 2**LOG2_WIN-sample windows, compares each
// average to a threshold and holds the result in a one-entry valid/ready buffer.
module detector_window_averager #(
   parameter int SAMPLE_W   = 12,
   parameter int LOG2_WIN   = 4,
   parameter bit CONTINUOUS = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                stop,
   input  logic                samp_valid,
   input  logic [SAMPLE_W-1:0] samp_data,
   input  logic [SAMPLE_W-1:0] thresh,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [SAMPLE_W-1:0] res_avg,
   output logic                res_hit,
   output logic                busy,
   output logic                overrun
);

   localparam int ACC_W = SAMPLE_W + LOG2_WIN;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [LOG2_WIN-1:0] cnt_q, cnt_d;
   logic                res_valid_q, res_valid_d;
   logic [SAMPLE_W-1:0] res_avg_q, res_avg_d;
   logic                res_hit_q, res_hit_d;
   logic                overrun_q, overrun_d;

   logic [ACC_W-1:0]    sum;
   logic [SAMPLE_W-1:0] avg;
   logic                pop;
   logic                take;
   logic                complete;

   assign sum  = acc_q + ACC_W'(samp_data);
   assign avg  = sum[ACC_W-1:LOG2_WIN];
   assign pop  = res_valid_q & res_ready;
   // stop and start both pre-empt sample intake in the same cycle
   assign take = (state_q == ACCUM) & samp_valid & ~start & ~stop;
   assign complete = take & (&cnt_q);

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      res_valid_d = res_valid_q & ~pop;
      res_avg_d   = res_avg_q;
      res_hit_d   = res_hit_q;
      overrun_d   = overrun_q;

      if (stop) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
      end else if (start) begin
         state_d   = ACCUM;
         acc_d     = '0;
         cnt_d     = '0;
         overrun_d = 1'b0;
      end else if (complete) begin
         acc_d   = '0;
         cnt_d   = '0;
         state_d = CONTINUOUS ? ACCUM : IDLE;
      end else if (take) begin
         acc_d = sum;
         cnt_d = cnt_q + 1'b1;
      end

      if (complete) begin
         if (!res_valid_q || pop) begin
            res_valid_d = 1'b1;
            res_avg_d   = avg;
            res_hit_d   = (avg >= thresh);
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         res_valid_q <= 1'b0;
         res_avg_q   <= '0;
         res_hit_q   <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         res_valid_q <= res_valid_d;
         res_avg_q   <= res_avg_d;
         res_hit_q   <= res_hit_d;
         overrun_q   <= overrun_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_avg   = res_avg_q;
   assign res_hit   = res_hit_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q == ACCUM);

endmodule

// File: tb/tb_detector_window_averager.sv
// Scoreboard bench for detector_window_averager: stimulus pushes expected
// results, a negedge monitor pops and compares on every accepted result.
module tb_detector_window_averager;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        samp_valid = 1'b0;
   logic [11:0] samp_data = '0;
   logic [11:0] thresh = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [11:0] res_avg;
   logic        res_hit;
   logic        busy;
   logic        overrun;

   int checks = 0;
   int failures = 0;
   logic [12:0] exp_q[$];

   detector_window_averager #(
      .SAMPLE_W(12),
      .LOG2_WIN(4),
      .CONTINUOUS(1'b1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .stop(stop),
      .samp_valid(samp_valid),
      .samp_data(samp_data),
      .thresh(thresh),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .res_avg(res_avg),
      .res_hit(res_hit),
      .busy(busy),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // monitor: every accepted result must match the head of the scoreboard
   always @(negedge clk) begin
      if (rst_n && res_valid && res_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_result: got avg=%0d hit=%0d expected none",
                     res_avg, res_hit);
         end else begin
            logic [12:0] e;
            e = exp_q.pop_front();
            if ({res_avg, res_hit} !== e) begin
               failures++;
               $display("FAIL result: got avg=%0d hit=%0d expected avg=%0d hit=%0d",
                        res_avg, res_hit, e[12:1], e[0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [11:0] d);
      samp_valid = 1'b1;
      samp_data  = d;
      tick();
      samp_valid = 1'b0;
   endtask

   task automatic feed_n(input logic [11:0] d, input int n);
      for (int i = 0; i < n; i++) feed(d);
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      #12;
      chk("reset_res_valid", res_valid, 0);
      chk("reset_res_avg", res_avg, 0);
      chk("reset_res_hit", res_hit, 0);
      chk("reset_busy", busy, 0);
      chk("reset_overrun", overrun, 0);
      rst_n = 1'b1;
      tick();

      // 1: sixteen samples of 100, threshold 100
      thresh = 12'd100;
      do_start();
      chk("t1_busy", busy, 1);
      exp_q.push_back({12'd100, 1'b1});
      feed_n(12'd100, 15);
      chk("t1_not_early", res_valid, 0);
      feed(12'd100);
      chk("t1_valid", res_valid, 1);
      chk("t1_avg", res_avg, 100);
      chk("t1_hit", res_hit, 1);
      chk("t1_overrun", overrun, 0);
      res_ready = 1'b1;
      tick();
      chk("t1_pop_clears", res_valid, 0);

      // 2: ramp 0..15 gives sum 120, avg 7
      thresh = 12'd8;
      exp_q.push_back({12'd7, 1'b0});
      for (int i = 0; i < 16; i++) feed(12'(i));
      chk("t2_avg", res_avg, 7);
      chk("t2_hit", res_hit, 0);
      tick();

      // 3: second window dropped while first is unconsumed
      res_ready = 1'b0;
      thresh = 12'd100;
      exp_q.push_back({12'd4095, 1'b1});
      feed_n(12'd4095, 16);
      chk("t3_overrun_pre", overrun, 0);
      feed_n(12'd2000, 16);
      tick();
      chk("t3_overrun", overrun, 1);
      chk("t3_avg_kept", res_avg, 4095);
      chk("t3_valid_kept", res_valid, 1);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("t3_popped", res_valid, 0);
      chk("t3_overrun_sticky", overrun, 1);
      do_start();
      chk("t3_overrun_clr", overrun, 0);
      chk("t3_busy", busy, 1);

      // 4: completion on the same cycle as a pop
      exp_q.push_back({12'd300, 1'b1});
      feed_n(12'd300, 16);
      exp_q.push_back({12'd500, 1'b1});
      feed_n(12'd500, 15);
      res_ready = 1'b1;
      feed(12'd500);
      chk("t4_valid_no_gap", res_valid, 1);
      chk("t4_new_avg", res_avg, 500);
      chk("t4_overrun", overrun, 0);
      tick();

      // 5: restart discards partial window; sample on start cycle ignored
      thresh = 12'd10;
      feed_n(12'd50, 7);
      samp_valid = 1'b1;
      samp_data = 12'd4000;
      do_start();
      samp_valid = 1'b0;
      exp_q.push_back({12'd20, 1'b1});
      feed_n(12'd20, 15);
      chk("t5_not_early", res_valid, 0);
      feed(12'd20);
      chk("t5_avg", res_avg, 20);
      tick();
      start = 1'b1;
      stop = 1'b1;
      tick();
      start = 1'b0;
      stop = 1'b0;
      chk("t5_stop_busy", busy, 0);
      feed_n(12'd900, 16);
      tick();
      chk("t5_idle_ignores", res_valid, 0);

      // 6: async reset with a result pending and a partial window
      res_ready = 1'b0;
      do_start();
      feed_n(12'd64, 16);
      feed_n(12'd64, 10);
      chk("t6_pending", res_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", res_valid, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_overrun", overrun, 0);
      tick();
      rst_n = 1'b1;
      tick();
      res_ready = 1'b1;
      feed_n(12'd64, 16);
      tick();
      chk("t6_ignored_valid", res_valid, 0);
      chk("t6_ignored_busy", busy, 0);
      thresh = 12'd8;
      do_start();
      exp_q.push_back({12'd7, 1'b0});
      feed_n(12'd7, 16);
      chk("t6_after_avg", res_avg, 7);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
